// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run/step/halt sequencer for the single-cycle CPU core. It sits between the
// top-level start/debug controls and the datapath and produces the commit
// enable that qualifies the PC update and the register/data-memory writes.
//
// Halt sources, highest priority first:
//   1 ext   : external halt request
//   2 bp    : PC breakpoint (masked in STEP and in the first RUN cycle)
//   3 zero  : all-zero sentinel instruction
//   4 limit : programmed cycle limit reached
// The instruction present in the halting cycle is never committed.
//
// Ports
//   clk_i         : clock
//   rst_i         : asynchronous reset, active-low
//   start_i       : level; enter/resume RUN from IDLE or HALT
//   step_i        : level; execute one instruction from IDLE or HALT
//   halt_i        : external halt request
//   clear_i       : from HALT, return to IDLE and zero the counter
//   max_cycles_i  : cycle limit, 0 = unlimited
//   bp_en_i       : breakpoint enable
//   bp_addr_i     : breakpoint PC
//   pc_i          : current PC from the CPU
//   instr_i       : instruction fetched at pc_i
//   cpu_en_o      : CPU may commit this cycle (combinational)
//   state_o       : 0 IDLE, 1 RUN, 2 STEP, 3 HALT
//   cycle_cnt_o   : instructions committed since clear/reset (saturating)
//   halted_o      : state is HALT
//   halt_cause_o  : 0 none, 1 ext, 2 bp, 3 zero instr, 4 limit
//   halt_pulse_o  : one-cycle pulse in the first HALT cycle after each entry
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             halt_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] max_cycles_i,
  input  logic             bp_en_i,
  input  logic [XLEN-1:0]  bp_addr_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  instr_i,
  output logic             cpu_en_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic             halted_o,
  output logic [2:0]       halt_cause_o,
  output logic             halt_pulse_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_EXT   = 3'd1;
  localparam logic [2:0] CAUSE_BP    = 3'd2;
  localparam logic [2:0] CAUSE_ZERO  = 3'd3;
  localparam logic [2:0] CAUSE_LIMIT = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]  INSTR_ZERO = {XLEN{1'b0}};

  // Registered state
  logic [1:0]       state_q,  state_d;
  logic             first_q,  first_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]       cause_q,  cause_d;
  logic             pulse_q,  pulse_d;

  // Halt detection
  logic             active_s;
  logic             bp_hit_s;
  logic             zero_hit_s;
  logic             limit_hit_s;
  logic [2:0]       halt_cause_s;
  logic             halt_now_s;
  logic             cpu_en_s;

  // Halt cause decode: priority-ordered, only meaningful while executing
  always_comb begin
    active_s    = (state_q == ST_RUN) || (state_q == ST_STEP);
    // Breakpoint is masked while stepping and in the first RUN cycle so that a
    // resume from a breakpoint commits the instruction at the breakpoint PC.
    bp_hit_s    = bp_en_i && (pc_i == bp_addr_i) &&
                  (state_q == ST_RUN) && !first_q;
    zero_hit_s  = (instr_i == INSTR_ZERO);
    limit_hit_s = (max_cycles_i != CNT_ZERO) && (cnt_q >= max_cycles_i);

    if (!active_s) begin
      halt_cause_s = CAUSE_NONE;
    end else if (halt_i) begin
      halt_cause_s = CAUSE_EXT;
    end else if (bp_hit_s) begin
      halt_cause_s = CAUSE_BP;
    end else if (zero_hit_s) begin
      halt_cause_s = CAUSE_ZERO;
    end else if (limit_hit_s) begin
      halt_cause_s = CAUSE_LIMIT;
    end else begin
      halt_cause_s = CAUSE_NONE;
    end

    halt_now_s = (halt_cause_s != CAUSE_NONE);
    cpu_en_s   = active_s && !halt_now_s;
  end

  // Next-state, counter, cause and pulse computation
  always_comb begin
    state_d = state_q;
    first_d = 1'b0;
    cause_d = cause_q;
    pulse_d = 1'b0;

    // Counter saturates instead of wrapping
    if (cpu_en_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          first_d = 1'b1;
        end else if (step_i) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (halt_now_s) begin
          state_d = ST_HALT;
          cause_d = halt_cause_s;
          pulse_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_STEP: begin
        if (halt_now_s) begin
          state_d = ST_HALT;
          cause_d = halt_cause_s;
          pulse_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_HALT: begin
        if (clear_i) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          cause_d = CAUSE_NONE;
        end else if (start_i) begin
          state_d = ST_RUN;
          first_d = 1'b1;
          cause_d = CAUSE_NONE;
        end else if (step_i) begin
          state_d = ST_STEP;
          cause_d = CAUSE_NONE;
        end else begin
          state_d = ST_HALT;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cause_d = CAUSE_NONE;
      end
    endcase
  end

  // State and status registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
      cause_q <= CAUSE_NONE;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      pulse_q <= pulse_d;
    end
  end

  assign cpu_en_o     = cpu_en_s;
  assign state_o      = state_q;
  assign cycle_cnt_o  = cnt_q;
  assign halted_o     = (state_q == ST_HALT);
  assign halt_cause_o = cause_q;
  assign halt_pulse_o = pulse_q;

endmodule
